// File: rtl/store_rmw_unit_pkg.sv
// Shared definitions for the store read-modify-write unit: op encodings,
// FSM state encoding and the default read timeout.
package store_rmw_unit_pkg;

   typedef enum logic [1:0] {
      ST_SW  = 2'b00,
      ST_SH  = 2'b01,
      ST_SB  = 2'b10,
      ST_RSV = 2'b11
   } st_op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WAIT  = 2'd2,
      S_WRITE = 2'd3
   } state_e;

   localparam int RD_TIMEOUT_DEFAULT = 16;

   // A request that can never be committed: misaligned word/halfword or the reserved op.
   function automatic logic st_req_bad(input logic [1:0] op, input logic [1:0] addr_lo);
      logic bad;
      case (op)
         ST_SW:   bad = (addr_lo != 2'b00);
         ST_SH:   bad = addr_lo[0];
         ST_SB:   bad = 1'b0;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/store_rmw_unit_if.sv
// Store request side (from MEM stage) and word-only data-memory port of the
// store read-modify-write unit.
interface store_rmw_unit_if;
   logic        st_valid;
   logic        st_ready;
   logic [1:0]  st_op;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        st_flush;
   logic        st_done;
   logic        st_err;

   logic [31:0] mem_addr;
   logic        mem_rd_en;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;
   logic        mem_wr_en;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;

   modport slave (
      input  st_valid, st_op, st_addr, st_data, st_flush, mem_rdata, mem_rvalid,
      output st_ready, st_done, st_err, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, mem_be
   );

   modport master (
      output st_valid, st_op, st_addr, st_data, st_flush, mem_rdata, mem_rvalid,
      input  st_ready, st_done, st_err, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, mem_be
   );
endinterface

// File: rtl/store_byte_merge.sv
// Combinational lane merge: places sw/sh/sb data into an existing 32-bit word
// and reports which byte lanes changed.
module store_byte_merge
   import store_rmw_unit_pkg::*;
(
   input  st_op_e      op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] old_word,
   input  logic [31:0] data,
   output logic [31:0] word,
   output logic [3:0]  be
);

   always_comb begin
      word = old_word;
      be   = 4'b0000;
      case (op)
         ST_SW: begin
            word = data;
            be   = 4'b1111;
         end
         ST_SH: begin
            if (addr_lo[1]) begin
               word[31:16] = data[15:0];
               be          = 4'b1100;
            end else begin
               word[15:0] = data[15:0];
               be         = 4'b0011;
            end
         end
         ST_SB: begin
            word[{addr_lo, 3'b000} +: 8] = data[7:0];
            be                           = 4'b0001 << addr_lo;
         end
         default: begin
            word = old_word;
            be   = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/store_rmw_unit.sv
// MEM-stage store unit: commits sw directly, performs read-modify-write for
// sh/sb against a word-only data memory, and rejects misaligned/reserved stores.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | ready for a request; bad requests pulse st_err next cycle
//   S_READ  | one-cycle mem_rd_en for the word holding the sub-word lane
//   S_WAIT  | waiting for mem_rvalid, bounded by RD_TIMEOUT idle cycles
//   S_WRITE | one-cycle full-word write, st_done pulses with it
module store_rmw_unit
   import store_rmw_unit_pkg::*;
#(
   parameter int RD_TIMEOUT = RD_TIMEOUT_DEFAULT
) (
   input  logic             clk,
   input  logic             reset_n,
   store_rmw_unit_if.slave  bus
);

   localparam int            CW     = $clog2(RD_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_TC = CW'(RD_TIMEOUT - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          accept;
   logic          merge_fire;
   logic          req_bad;

   st_op_e        op_q;
   logic [31:0]   addr_q;
   logic [31:0]   data_q;
   logic [31:0]   wdata_q;
   logic [3:0]    be_q;
   logic [31:0]   merge_word;
   logic [3:0]    merge_be;

   assign req_bad = st_req_bad(bus.st_op, bus.st_addr[1:0]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Flush takes priority over both read data and timeout while a read is pending.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      err_d      = 1'b0;
      accept     = 1'b0;
      merge_fire = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.st_valid) begin
               accept = 1'b1;
               if (req_bad) begin
                  err_d = 1'b1;
               end else if (bus.st_op == ST_SW) begin
                  state_d = S_WRITE;
               end else begin
                  state_d = S_READ;
               end
            end
         end
         S_READ: begin
            cnt_d   = '0;
            state_d = bus.st_flush ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            if (bus.st_flush) begin
               state_d = S_IDLE;
            end else if (bus.mem_rvalid) begin
               merge_fire = 1'b1;
               state_d    = S_WRITE;
            end else if (cnt_q == CNT_TC) begin
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WRITE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q    <= ST_SW;
         addr_q  <= '0;
         data_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else if (accept) begin
         op_q   <= st_op_e'(bus.st_op);
         addr_q <= bus.st_addr;
         data_q <= bus.st_data;
         if (!req_bad && bus.st_op == ST_SW) begin
            wdata_q <= bus.st_data;
            be_q    <= 4'b1111;
         end
      end else if (merge_fire) begin
         wdata_q <= merge_word;
         be_q    <= merge_be;
      end
   end

   store_byte_merge u_merge (
      .op       (op_q),
      .addr_lo  (addr_q[1:0]),
      .old_word (bus.mem_rdata),
      .data     (data_q),
      .word     (merge_word),
      .be       (merge_be)
   );

   assign bus.st_ready  = (state_q == S_IDLE);
   assign bus.mem_rd_en = (state_q == S_READ);
   assign bus.mem_wr_en = (state_q == S_WRITE);
   assign bus.st_done   = (state_q == S_WRITE);
   assign bus.st_err    = err_q;
   assign bus.mem_addr  = {addr_q[31:2], 2'b00};
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_be    = be_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed and randomized checks of store_rmw_unit against a word-memory model
// with lane replacement computed arithmetically.
module tb_store_rmw_unit;

   localparam int TMO = 16;

   logic clk;
   logic reset_n;
   int   vectors;
   int   miscompares;

   logic [31:0] mem [logic [31:0]];

   store_rmw_unit_if bus ();

   store_rmw_unit #(.RD_TIMEOUT(TMO)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] waddr);
      if (!mem.exists(waddr)) mem[waddr] = $urandom;
      return mem[waddr];
   endfunction

   function automatic logic [31:0] ref_word(input logic [1:0] op, input logic [31:0] addr,
                                            input logic [31:0] old, input logic [31:0] data);
      int          sh;
      logic [31:0] mask;
      if (op == 2'b00) return data;
      if (op == 2'b01) begin
         sh   = addr[1] ? 16 : 0;
         mask = 32'h0000_FFFF << sh;
         return (old & ~mask) | ((data & 32'h0000_FFFF) << sh);
      end
      sh   = 8 * int'(addr[1:0]);
      mask = 32'h0000_00FF << sh;
      return (old & ~mask) | ((data & 32'h0000_00FF) << sh);
   endfunction

   function automatic logic [3:0] ref_be(input logic [1:0] op, input logic [31:0] addr);
      if (op == 2'b00) return 4'b1111;
      if (op == 2'b01) return addr[1] ? 4'b1100 : 4'b0011;
      return 4'b0001 << addr[1:0];
   endfunction

   function automatic logic ref_bad(input logic [1:0] op, input logic [31:0] addr);
      return (op == 2'b11) || (op == 2'b00 && addr[1:0] != 2'b00) || (op == 2'b01 && addr[0]);
   endfunction

   // Called at a falling edge; returns at the falling edge after the accepting rising edge.
   task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
      bus.st_valid = 1'b1;
      bus.st_op    = op;
      bus.st_addr  = addr;
      bus.st_data  = data;
      @(negedge clk);
      bus.st_valid = 1'b0;
      bus.st_data  = $urandom;
   endtask

   task automatic run_store(input logic [1:0] op, input logic [31:0] addr,
                            input logic [31:0] data, input int lat);
      logic [31:0] waddr;
      logic [31:0] old;
      logic [31:0] exp_w;
      waddr = {addr[31:2], 2'b00};
      check("ready_before", bus.st_ready, 1);
      issue(op, addr, data);
      if (ref_bad(op, addr)) begin
         check("bad_err", bus.st_err, 1);
         check("bad_done", bus.st_done, 0);
         check("bad_rd", bus.mem_rd_en, 0);
         check("bad_wr", bus.mem_wr_en, 0);
         check("bad_ready", bus.st_ready, 1);
         @(negedge clk);
         check("bad_err_pulse", bus.st_err, 0);
         check("bad_rd_after", bus.mem_rd_en, 0);
         check("bad_wr_after", bus.mem_wr_en, 0);
      end else if (op == 2'b00) begin
         check("sw_wr", bus.mem_wr_en, 1);
         check("sw_done", bus.st_done, 1);
         check("sw_err", bus.st_err, 0);
         check("sw_rd", bus.mem_rd_en, 0);
         check("sw_wdata", bus.mem_wdata, data);
         check("sw_be", bus.mem_be, 4'b1111);
         check("sw_addr", bus.mem_addr, waddr);
         mem[waddr] = data;
         @(negedge clk);
         check("sw_wr_once", bus.mem_wr_en, 0);
         check("sw_ready_after", bus.st_ready, 1);
      end else begin
         check("rmw_rd", bus.mem_rd_en, 1);
         check("rmw_wr_early", bus.mem_wr_en, 0);
         check("rmw_addr", bus.mem_addr, waddr);
         check("rmw_ready_busy", bus.st_ready, 0);
         @(negedge clk);
         check("rmw_rd_once", bus.mem_rd_en, 0);
         for (int i = 0; i < lat; i++) begin
            check("rmw_wait_wr", bus.mem_wr_en, 0);
            check("rmw_wait_err", bus.st_err, 0);
            @(negedge clk);
         end
         old            = mem_word(waddr);
         exp_w          = ref_word(op, addr, old, data);
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = old;
         @(negedge clk);
         bus.mem_rvalid = 1'b0;
         bus.mem_rdata  = $urandom;
         check("rmw_wr", bus.mem_wr_en, 1);
         check("rmw_done", bus.st_done, 1);
         check("rmw_err", bus.st_err, 0);
         check("rmw_wdata", bus.mem_wdata, exp_w);
         check("rmw_be", bus.mem_be, ref_be(op, addr));
         check("rmw_addr_hold", bus.mem_addr, waddr);
         mem[waddr] = exp_w;
         @(negedge clk);
         check("rmw_wr_once", bus.mem_wr_en, 0);
         check("rmw_done_once", bus.st_done, 0);
         check("rmw_ready_after", bus.st_ready, 1);
      end
   endtask

   initial begin
      logic [1:0]  op;
      logic [31:0] addr;
      int          r;
      vectors        = 0;
      miscompares    = 0;
      reset_n        = 1'b0;
      bus.st_valid   = 1'b0;
      bus.st_op      = 2'b00;
      bus.st_addr    = '0;
      bus.st_data    = '0;
      bus.st_flush   = 1'b0;
      bus.mem_rdata  = '0;
      bus.mem_rvalid = 1'b0;

      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_ready", bus.st_ready, 1);
      check("rst_done", bus.st_done, 0);
      check("rst_err", bus.st_err, 0);
      check("rst_rd", bus.mem_rd_en, 0);
      check("rst_wr", bus.mem_wr_en, 0);
      check("rst_addr", bus.mem_addr, 0);
      check("rst_wdata", bus.mem_wdata, 0);
      check("rst_be", bus.mem_be, 0);

      run_store(2'b00, 32'h10, 32'hDEAD_BEEF, 0);
      check("sw_mem", mem[32'h10], 32'hDEAD_BEEF);
      mem[32'h10] = 32'h1122_3344;
      run_store(2'b10, 32'h13, 32'h0000_00AB, 1);
      check("sb_mem", mem[32'h10], 32'hAB22_3344);
      mem[32'h20] = 32'h1122_3344;
      run_store(2'b01, 32'h22, 32'h0000_CAFE, 2);
      check("sh_mem", mem[32'h20], 32'hCAFE_3344);
      run_store(2'b01, 32'h21, 32'h1234_5678, 0);
      run_store(2'b00, 32'h12, 32'h1234_5678, 0);
      run_store(2'b11, 32'h30, 32'h1234_5678, 0);

      // Read timeout, then a late rvalid that must not produce a write.
      issue(2'b10, 32'h44, 32'h77);
      check("tmo_rd", bus.mem_rd_en, 1);
      @(negedge clk);
      for (int i = 0; i < TMO; i++) begin
         check("tmo_wait_err", bus.st_err, 0);
         check("tmo_wait_ready", bus.st_ready, 0);
         @(negedge clk);
      end
      check("tmo_err", bus.st_err, 1);
      check("tmo_ready", bus.st_ready, 1);
      check("tmo_wr", bus.mem_wr_en, 0);
      check("tmo_done", bus.st_done, 0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hFFFF_FFFF;
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      check("tmo_late_wr", bus.mem_wr_en, 0);
      check("tmo_late_err", bus.st_err, 0);
      check("tmo_late_rd", bus.mem_rd_en, 0);

      // Flush while waiting for read data.
      issue(2'b10, 32'h51, 32'h3C);
      @(negedge clk);
      bus.st_flush = 1'b1;
      @(negedge clk);
      bus.st_flush   = 1'b0;
      check("flw_ready", bus.st_ready, 1);
      check("flw_wr", bus.mem_wr_en, 0);
      check("flw_done", bus.st_done, 0);
      check("flw_err", bus.st_err, 0);
      bus.mem_rvalid = 1'b1;
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      check("flw_late_wr", bus.mem_wr_en, 0);
      check("flw_late_done", bus.st_done, 0);

      // Flush during the read strobe.
      issue(2'b01, 32'h60, 32'hBEEF);
      check("flr_rd", bus.mem_rd_en, 1);
      bus.st_flush = 1'b1;
      @(negedge clk);
      bus.st_flush = 1'b0;
      check("flr_ready", bus.st_ready, 1);
      check("flr_rd_after", bus.mem_rd_en, 0);
      check("flr_err", bus.st_err, 0);

      // Flush held across an sw accept and its write must not cancel the commit.
      bus.st_flush = 1'b1;
      run_store(2'b00, 32'h70, 32'h0BAD_F00D, 0);
      bus.st_flush = 1'b0;

      // Reset in the middle of a read-modify-write.
      issue(2'b10, 32'h82, 32'h5A);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("arst_rd", bus.mem_rd_en, 0);
      check("arst_wr", bus.mem_wr_en, 0);
      check("arst_done", bus.st_done, 0);
      check("arst_err", bus.st_err, 0);
      check("arst_wdata", bus.mem_wdata, 0);
      check("arst_be", bus.mem_be, 0);
      check("arst_addr", bus.mem_addr, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("arst_ready_after", bus.st_ready, 1);
      run_store(2'b01, 32'h82, 32'h1357, 1);

      for (int i = 0; i < 120; i++) begin
         r = $urandom_range(0, 9);
         op = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
         addr = 32'h100 + 32'($urandom_range(0, 31));
         if ($urandom_range(0, 3) != 0 && op == 2'b00) addr[1:0] = 2'b00;
         if ($urandom_range(0, 3) != 0 && op == 2'b01) addr[0] = 1'b0;
         run_store(op, addr, $urandom, $urandom_range(0, 5));
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
